uart_param: RTL and testbench

Parametrised UART transceiver: one TX and one RX channel with configurable data width, parity, stop bits and baud rate. It adds 16x-oversampled majority-vote reception, false-start rejection, parity and framing error flags, a valid/ready TX handshake and an internal loopback mode. It sits between the board-level control logic (button, switches, LEDs) and the RxD/TxD pins, and supersedes separate TX, RX and clock-divider blocks.

---
 rtl/uart_param.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// Parametrised UART transceiver: one TX and one RX channel, 16x oversampled RX with
// 2-of-3 majority voting, parity/framing flags, valid/ready TX handshake, internal loopback.
module uart_param #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int BIT_CYC = 16 * DIV;
  localparam int TW      = $clog2(BIT_CYC + 1);
  localparam logic [TW-1:0] T_END = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] T_S0  = TW'(7 * DIV);
  localparam logic [TW-1:0] T_S1  = TW'(8 * DIV);
  localparam logic [TW-1:0] T_S2  = TW'(9 * DIV);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  // state | meaning: IDLE line idle, START start bit, DATA data bits, PARITY parity bit, STOP stop bit(s)
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  state_t                 tx_state_q, rx_state_q;
  logic [TW-1:0]          tx_timer_q, rx_timer_q;
  logic [3:0]             tx_bit_q, rx_bit_q;
  logic                   tx_stop_q, rx_stop_q;
  logic [DATA_BITS-1:0]   tx_shift_q, rx_shift_q, rx_data_q;
  logic                   tx_par_q, txd_q, tx_ready_q;
  logic                   rxd_meta_q, rxd_sync_q, rx_prev_q, lb_q;
  logic                   rx_s0_q, rx_s1_q, rx_perr_acc_q, rx_ferr_acc_q;
  logic                   rx_valid_q, rx_perr_q, rx_ferr_q;
  logic                   rx_line, rx_bit_d;

  assign rx_line  = lb_q ? txd_q : rxd_sync_q;
  assign rx_bit_d = (rx_s0_q & rx_s1_q) | (rx_s0_q & rx_line) | (rx_s1_q & rx_line);

  assign txd           = lb_q | txd_q;
  assign tx_ready      = tx_ready_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      lb_q       <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rx_prev_q  <= rx_line;
      if (tx_state_q == S_IDLE && rx_state_q == S_IDLE) lb_q <= loopback;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_timer_q <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
    end else if (tx_state_q == S_IDLE) begin
      if (tx_valid) begin
        tx_shift_q <= tx_data;
        tx_par_q   <= par_bit(tx_data);
        txd_q      <= 1'b0;
        tx_ready_q <= 1'b0;
        tx_timer_q <= '0;
        tx_state_q <= S_START;
      end
    end else if (tx_timer_q != T_END) begin
      tx_timer_q <= tx_timer_q + 1'b1;
    end else begin
      tx_timer_q <= '0;
      case (tx_state_q)
        S_START: begin
          tx_state_q <= S_DATA;
          tx_bit_q   <= '0;
          txd_q      <= tx_shift_q[0];
        end
        S_DATA: begin
          if (tx_bit_q == LAST_BIT) begin
            tx_stop_q <= 1'b0;
            if (PARITY != 0) begin
              tx_state_q <= S_PARITY;
              txd_q      <= tx_par_q;
            end else begin
              tx_state_q <= S_STOP;
              txd_q      <= 1'b1;
            end
          end else begin
            tx_bit_q   <= tx_bit_q + 4'd1;
            tx_shift_q <= tx_shift_q >> 1;
            txd_q      <= tx_shift_q[1];
          end
        end
        S_PARITY: begin
          tx_state_q <= S_STOP;
          tx_stop_q  <= 1'b0;
          txd_q      <= 1'b1;
        end
        S_STOP: begin
          // A still-valid request chains straight into the next start bit, no idle cycle.
          if (tx_stop_q != LAST_STOP) begin
            tx_stop_q <= 1'b1;
          end else if (tx_valid) begin
            tx_shift_q <= tx_data;
            tx_par_q   <= par_bit(tx_data);
            txd_q      <= 1'b0;
            tx_state_q <= S_START;
          end else begin
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_state_q <= S_IDLE;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q    <= S_IDLE;
      rx_timer_q    <= '0;
      rx_bit_q      <= '0;
      rx_stop_q     <= 1'b0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_s0_q       <= 1'b0;
      rx_s1_q       <= 1'b0;
      rx_perr_acc_q <= 1'b0;
      rx_ferr_acc_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (rx_state_q == S_IDLE) begin
        if (rx_prev_q && !rx_line) begin
          rx_timer_q <= '0;
          rx_state_q <= S_START;
        end
      end else begin
        rx_timer_q <= (rx_timer_q == T_END) ? '0 : rx_timer_q + 1'b1;
        if (rx_timer_q == T_S0) rx_s0_q <= rx_line;
        if (rx_timer_q == T_S1) rx_s1_q <= rx_line;
        if (rx_timer_q == T_S2) begin
          case (rx_state_q)
            S_START: begin
              if (rx_bit_d) begin
                rx_state_q <= S_IDLE;
              end else begin
                rx_perr_acc_q <= 1'b0;
                rx_ferr_acc_q <= 1'b0;
              end
            end
            S_DATA:   rx_shift_q <= {rx_bit_d, rx_shift_q[DATA_BITS-1:1]};
            S_PARITY: rx_perr_acc_q <= (rx_bit_d != par_bit(rx_shift_q));
            S_STOP: begin
              // Finish right after the last stop sample so the next start edge is caught.
              if (rx_stop_q == LAST_STOP) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_shift_q;
                rx_perr_q  <= rx_perr_acc_q;
                rx_ferr_q  <= rx_ferr_acc_q | ~rx_bit_d;
                rx_state_q <= S_IDLE;
              end else if (!rx_bit_d) begin
                rx_ferr_acc_q <= 1'b1;
              end
            end
            default: rx_state_q <= S_IDLE;
          endcase
        end else if (rx_timer_q == T_END) begin
          case (rx_state_q)
            S_START: begin
              rx_state_q <= S_DATA;
              rx_bit_q   <= '0;
            end
            S_DATA: begin
              if (rx_bit_q == LAST_BIT) begin
                rx_stop_q  <= 1'b0;
                rx_state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                rx_bit_q <= rx_bit_q + 4'd1;
              end
            end
            S_PARITY: begin
              rx_stop_q  <= 1'b0;
              rx_state_q <= S_STOP;
            end
            S_STOP:  rx_stop_q <= 1'b1;
            default: rx_state_q <= S_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: 8N1 (loopback, framing, false start, reset), 8E1 parity
// and 7O2 transmit waveform, all at DIV=10 (160 cycles per bit).
module tb_uart_param;
  localparam int CF = 1_600_000;
  localparam int BR = 10_000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] tx_data_a, rx_data_a, tx_data_b, rx_data_b;
  logic [6:0] tx_data_c, rx_data_c;
  logic tx_valid_a, tx_ready_a, txd_a, rxd_a, loopback_a, rx_valid_a, perr_a, ferr_a;
  logic tx_valid_b, tx_ready_b, txd_b, rxd_b, loopback_b, rx_valid_b, perr_b, ferr_b;
  logic tx_valid_c, tx_ready_c, txd_c, rxd_c, loopback_c, rx_valid_c, perr_c, ferr_c;

  uart_param #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .txd(txd_a), .rxd(rxd_a), .loopback(loopback_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a));

  uart_param #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .txd(txd_b), .rxd(rxd_b), .loopback(loopback_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_parity_err(perr_b), .rx_frame_err(ferr_b));

  uart_param #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset), .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
    .txd(txd_c), .rxd(rxd_c), .loopback(loopback_c), .rx_data(rx_data_c), .rx_valid(rx_valid_c),
    .rx_parity_err(perr_c), .rx_frame_err(ferr_c));

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt_a = 0, vcnt_b = 0, txd_low_a = 0, rdy_low_a = 0;

  always_ff @(posedge clk) begin
    if (rx_valid_a) vcnt_a <= vcnt_a + 1;
    if (rx_valid_b) vcnt_b <= vcnt_b + 1;
  end

  always_ff @(negedge clk) begin
    if (!txd_a) txd_low_a <= txd_low_a + 1;
    if (!tx_ready_a) rdy_low_a <= rdy_low_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rxd_a = v;
    else rxd_b = v;
  endtask

  task automatic send_rx(input int which, input logic [7:0] data, input logic has_par,
                         input logic par, input logic stop_v, input logic idle_v);
    set_rx(which, 1'b0);
    hold(160);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, data[i]);
      hold(160);
    end
    if (has_par) begin
      set_rx(which, par);
      hold(160);
    end
    set_rx(which, stop_v);
    hold(160);
    set_rx(which, idle_v);
  endtask

  task automatic send_tx_a(input logic [7:0] d);
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    @(posedge clk);
    #1 tx_valid_a = 1'b0;
  endtask

  task automatic wait_rx_a(input int v0, input int budget);
    int n = 0;
    while (vcnt_a == v0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rx_valid_a_timeout", 32'(vcnt_a != v0), 32'd1);
  endtask

  logic        txd_log [0:3599];
  logic        rdy_log [0:3599];
  logic [10:0] exp_seq;
  int v0, t0, r0, low_cnt;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tx_data_a = '0; tx_valid_a = 1'b0; rxd_a = 1'b1; loopback_a = 1'b0;
    tx_data_b = '0; tx_valid_b = 1'b0; rxd_b = 1'b1; loopback_b = 1'b0;
    tx_data_c = '0; tx_valid_c = 1'b0; rxd_c = 1'b1; loopback_c = 1'b0;
    hold(4);
    chk("rst_txd_a",     32'(txd_a), 32'd1);
    chk("rst_ready_a",   32'(tx_ready_a), 32'd1);
    chk("rst_valid_a",   32'(rx_valid_a), 32'd0);
    chk("rst_data_a",    32'(rx_data_a), 32'd0);
    chk("rst_errs_a",    32'({perr_a, ferr_a}), 32'd0);
    chk("rst_txd_c",     32'(txd_c), 32'd1);
    reset = 1'b0;
    hold(4);

    // 8N1 loopback 0xA5
    loopback_a = 1'b1;
    hold(3);
    v0 = vcnt_a; t0 = txd_low_a; r0 = rdy_low_a;
    send_tx_a(8'hA5);
    wait_rx_a(v0, 2500);
    chk("lb_data",  32'(rx_data_a), 32'hA5);
    chk("lb_perr",  32'(perr_a), 32'd0);
    chk("lb_ferr",  32'(ferr_a), 32'd0);
    hold(200);
    chk("lb_valid_count", 32'(vcnt_a - v0), 32'd1);
    chk("lb_txd_pin_low", 32'(txd_low_a - t0), 32'd0);
    chk("lb_ready_low",   32'(rdy_low_a - r0), 32'd1600);
    loopback_a = 1'b0;
    hold(10);

    // 8E1 parity
    v0 = vcnt_b;
    send_rx(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("par_bad_count", 32'(vcnt_b - v0), 32'd1);
    chk("par_bad_data",  32'(rx_data_b), 32'h3C);
    chk("par_bad_perr",  32'(perr_b), 32'd1);
    chk("par_bad_ferr",  32'(ferr_b), 32'd0);
    hold(100);
    send_rx(1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("par_ok_count", 32'(vcnt_b - v0), 32'd2);
    chk("par_ok_perr",  32'(perr_b), 32'd0);
    hold(100);
    send_rx(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("par_07_data", 32'(rx_data_b), 32'h07);
    chk("par_07_perr", 32'(perr_b), 32'd0);
    hold(100);
    send_rx(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("par_07bad_perr", 32'(perr_b), 32'd1);
    hold(100);

    // 8N1 framing error followed by a break
    v0 = vcnt_a;
    send_rx(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fe_count", 32'(vcnt_a - v0), 32'd1);
    chk("fe_data",  32'(rx_data_a), 32'h81);
    chk("fe_ferr",  32'(ferr_a), 32'd1);
    hold(480);
    chk("fe_break_count", 32'(vcnt_a - v0), 32'd1);
    rxd_a = 1'b1;
    hold(320);
    send_rx(0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("fe_recover_count", 32'(vcnt_a - v0), 32'd2);
    chk("fe_recover_ferr",  32'(ferr_a), 32'd0);
    hold(100);

    // false start
    v0 = vcnt_a;
    rxd_a = 1'b0;
    hold(40);
    rxd_a = 1'b1;
    hold(400);
    chk("fs_count", 32'(vcnt_a - v0), 32'd0);
    chk("fs_data",  32'(rx_data_a), 32'h81);
    chk("fs_flags", 32'({perr_a, ferr_a}), 32'd0);
    send_rx(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("fs_next_count", 32'(vcnt_a - v0), 32'd1);
    chk("fs_next_data",  32'(rx_data_a), 32'h5A);
    hold(100);

    // 7O2 waveform and back-to-back frames
    tx_data_c = 7'h55;
    exp_seq = {3'b111, 7'h55, 1'b0};
    @(posedge clk);
    #1 tx_valid_c = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 3600; c++) begin
      @(negedge clk);
      txd_log[c] = txd_c;
      rdy_log[c] = tx_ready_c;
      if (c == 1800) tx_valid_c = 1'b0;
    end
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 11; i++)
        chk($sformatf("c7o2_f%0d_bit%0d", f, i), 32'(txd_log[f*1760 + i*160 + 80]), 32'(exp_seq[i]));
    chk("c7o2_last_stop_end", 32'(txd_log[1759]), 32'd1);
    chk("c7o2_no_gap_start",  32'(txd_log[1760]), 32'd0);
    low_cnt = 0;
    for (int c = 0; c < 3600; c++) if (!rdy_log[c]) low_cnt++;
    chk("c7o2_ready_low", 32'(low_cnt), 32'd3520);
    chk("c7o2_ready_rise", 32'(rdy_log[3520]), 32'd1);
    chk("c7o2_idle_txd",   32'(txd_log[3599]), 32'd1);

    // reset mid-frame: TX in data bit 4, RX in data bit 2
    v0 = vcnt_a;
    tx_data_a  = 8'h00;
    tx_valid_a = 1'b1;
    @(posedge clk);
    #1 tx_valid_a = 1'b0;
    hold(319);
    rxd_a = 1'b0; hold(160);
    rxd_a = 1'b1; hold(160);
    rxd_a = 1'b1; hold(160);
    rxd_a = 1'b1; hold(80);
    chk("mid_ready_a", 32'(tx_ready_a), 32'd0);
    chk("mid_txd_a",   32'(txd_a), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_mid_txd",   32'(txd_a), 32'd1);
    chk("rst_mid_ready", 32'(tx_ready_a), 32'd1);
    chk("rst_mid_valid", 32'(rx_valid_a), 32'd0);
    chk("rst_mid_data",  32'(rx_data_a), 32'd0);
    rxd_a = 1'b1;
    hold(3);
    reset = 1'b0;
    hold(400);
    chk("rst_partial_count", 32'(vcnt_a - v0), 32'd0);
    loopback_a = 1'b1;
    hold(3);
    v0 = vcnt_a;
    send_tx_a(8'hC3);
    wait_rx_a(v0, 2500);
    chk("rst_after_data",  32'(rx_data_a), 32'hC3);
    chk("rst_after_flags", 32'({perr_a, ferr_a}), 32'd0);
    hold(200);
    chk("rst_after_ready", 32'(tx_ready_a), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
